// File: rtl/tt_um_jimktrains_vslc_servo_ctrl_pkg.sv
// Shared constants and register-decode helpers for the servo sequencer.
package tt_um_jimktrains_vslc_servo_ctrl_pkg;

    // Config bus address map
    localparam logic [3:0] ADDR_PRE_LO  = 4'h0;
    localparam logic [3:0] ADDR_PRE_HI  = 4'h1;
    localparam logic [3:0] ADDR_FREQ    = 4'h2;
    localparam logic [3:0] ADDR_CTRL    = 4'h3;
    localparam logic [3:0] ADDR_CH_BASE = 4'h4;

    // CTRL bit that requests a shadow->active commit
    localparam int CTRL_COMMIT_BIT = 7;

    // Per-channel values loaded by reset
    localparam logic [4:0] RST_SET_VAL   = 5'd10;
    localparam logic [4:0] RST_RESET_VAL = 5'd20;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_PRE_LO,
        REG_PRE_HI,
        REG_FREQ,
        REG_CTRL,
        REG_CH_SET,
        REG_CH_RESET
    } reg_sel_e;

    // Map a bus address to the shadow register it targets. Channel registers
    // beyond the instantiated channel count decode to REG_NONE.
    function automatic reg_sel_e decode_reg(input logic [3:0] addr, input int num_ch);
        reg_sel_e   sel;
        logic [3:0] off;
        sel = REG_NONE;
        off = addr - ADDR_CH_BASE;
        case (addr)
            ADDR_PRE_LO: sel = REG_PRE_LO;
            ADDR_PRE_HI: sel = REG_PRE_HI;
            ADDR_FREQ:   sel = REG_FREQ;
            ADDR_CTRL:   sel = REG_CTRL;
            default: begin
                if (addr >= ADDR_CH_BASE && int'(off[3:1]) < num_ch) begin
                    sel = off[0] ? REG_CH_RESET : REG_CH_SET;
                end
            end
        endcase
        return sel;
    endfunction

    // Channel index addressed by a SET/RESET register address.
    function automatic logic [2:0] chan_of(input logic [3:0] addr);
        return 3'((addr - ADDR_CH_BASE) >> 1);
    endfunction

endpackage

// File: rtl/tt_um_jimktrains_vslc_servo_prescaler.sv
// Servo tick prescaler: counts 0..i_reload and emits a one-clk tick on the
// terminal count. A reload of 0 gives a tick on every clock.
module tt_um_jimktrains_vslc_servo_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PRESCALE_W-1:0] i_reload,
    input  logic                  i_clear,
    output logic                  o_tick
);

    logic [PRESCALE_W-1:0] r_cnt;

    assign o_tick = (r_cnt == i_reload);

    // Count up, wrap after the tick cycle, restart from 0 on a synchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tt_um_jimktrains_vslc_servo_ctrl.sv
// Servo channel sequencer: config register file, shared tick prescaler,
// frame counter and frame-aligned shadow->active commit.
module tt_um_jimktrains_vslc_servo_ctrl
    import tt_um_jimktrains_vslc_servo_ctrl_pkg::*;
#(
    parameter int                    NUM_CH       = 2,
    parameter int                    PRESCALE_W   = 16,
    parameter logic [PRESCALE_W-1:0] RST_PRESCALE = PRESCALE_W'(999),
    parameter logic [7:0]            RST_FREQ     = 8'd199
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [3:0]            cfg_addr,
    input  logic [7:0]            cfg_data,
    output logic                  servo_clk,
    output logic [7:0]            servo_freq_val,
    output logic [5*NUM_CH-1:0]   servo_set_val,
    output logic [5*NUM_CH-1:0]   servo_reset_val,
    output logic [NUM_CH-1:0]     servo_enabled,
    output logic                  frame_start,
    output logic                  commit_pending
);

    // Shadow registers are 16 bits wide on the prescale side so both address
    // bytes always have a home; only the low PRESCALE_W bits are committed.
    logic [15:0]            r_pre_sh;
    logic [7:0]             r_freq_sh;
    logic [NUM_CH-1:0]      r_en_sh;
    logic [5*NUM_CH-1:0]    r_set_sh;
    logic [5*NUM_CH-1:0]    r_rst_sh;

    logic [PRESCALE_W-1:0]  r_pre_act;
    logic [7:0]             r_freq_act;
    logic [NUM_CH-1:0]      r_en_act;
    logic [5*NUM_CH-1:0]    r_set_act;
    logic [5*NUM_CH-1:0]    r_rst_act;

    logic [7:0]             r_fcnt;
    logic                   r_pending;

    logic                   w_wr;
    reg_sel_e               w_sel;
    logic [2:0]             w_ch;
    logic                   w_tick;
    logic                   w_idle;
    logic                   w_boundary;
    logic                   w_commit;

    assign w_wr  = cfg_valid && cfg_ready;
    assign w_sel = decode_reg(cfg_addr, NUM_CH);
    assign w_ch  = chan_of(cfg_addr);

    // With no channel enabled every tick is a frame boundary, so a commit
    // never waits longer than one tick.
    assign w_idle     = (r_en_act == '0);
    assign w_boundary = w_idle || (r_fcnt == r_freq_act);
    assign w_commit   = w_tick && w_boundary && r_pending;

    tt_um_jimktrains_vslc_servo_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_reload (r_pre_act),
        .i_clear  (w_commit),
        .o_tick   (w_tick)
    );

    // Shadow register file written by accepted config transactions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_sh  <= 16'(RST_PRESCALE);
            r_freq_sh <= RST_FREQ;
            r_en_sh   <= '0;
            r_set_sh  <= {NUM_CH{RST_SET_VAL}};
            r_rst_sh  <= {NUM_CH{RST_RESET_VAL}};
        end else if (w_wr) begin
            case (w_sel)
                REG_PRE_LO: r_pre_sh[7:0]  <= cfg_data;
                REG_PRE_HI: r_pre_sh[15:8] <= cfg_data;
                REG_FREQ:   r_freq_sh      <= cfg_data;
                REG_CTRL:   r_en_sh        <= cfg_data[NUM_CH-1:0];
                REG_CH_SET: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (w_ch == 3'(c)) r_set_sh[5*c +: 5] <= cfg_data[4:0];
                    end
                end
                REG_CH_RESET: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (w_ch == 3'(c)) r_rst_sh[5*c +: 5] <= cfg_data[4:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Active registers take the whole shadow set at once on a commit edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_act  <= RST_PRESCALE;
            r_freq_act <= RST_FREQ;
            r_en_act   <= '0;
            r_set_act  <= {NUM_CH{RST_SET_VAL}};
            r_rst_act  <= {NUM_CH{RST_RESET_VAL}};
        end else if (w_commit) begin
            r_pre_act  <= PRESCALE_W'(r_pre_sh);
            r_freq_act <= r_freq_sh;
            r_en_act   <= r_en_sh;
            r_set_act  <= r_set_sh;
            r_rst_act  <= r_rst_sh;
        end
    end

    // Commit request flag: set by a CTRL write with the commit bit, cleared when applied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if (w_commit) begin
            r_pending <= 1'b0;
        end else if (w_wr && w_sel == REG_CTRL && cfg_data[CTRL_COMMIT_BIT]) begin
            r_pending <= 1'b1;
        end
    end

    // Frame counter tracking the channel counters, restarted by a commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt <= '0;
        end else if (w_commit) begin
            r_fcnt <= '0;
        end else if (w_tick) begin
            r_fcnt <= w_boundary ? 8'd0 : r_fcnt + 8'd1;
        end
    end

    assign cfg_ready       = !r_pending;
    assign commit_pending  = r_pending;
    assign servo_clk       = w_tick;
    assign frame_start     = w_tick && w_boundary;
    assign servo_freq_val  = r_freq_act;
    assign servo_set_val   = r_set_act;
    assign servo_reset_val = r_rst_act;
    assign servo_enabled   = r_en_act;

endmodule
